// File: rtl/csa_pipe_adder_if.sv
// Operand/result bus of csa_pipe_adder.
// master: producer of operands and consumer of results (the environment).
// slave : the adder itself.
// Signals:
//   in_valid/in_ready   operand beat handshake
//   in_x, in_y          operands
//   in_cin              carry-in (ignored in subtract mode)
//   in_sub              0: x + y + cin, 1: x - y
//   out_valid/out_ready result beat handshake
//   out_sum             result modulo 2^WIDTH
//   out_cout            carry out of the MSB (1 = no borrow when subtracting)
//   out_ovf             two's-complement signed overflow
interface csa_pipe_adder_if #(
  parameter int unsigned WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_y, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// The operand is cut into BLK-bit carry-select blocks; each pipeline stage resolves GRP
// blocks, giving STAGES = WIDTH/(BLK*GRP) register stages and a latency of STAGES cycles
// from the accepting edge (inclusive). WIDTH must be a multiple of BLK*GRP.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; discards everything in flight
//   bus  csa_pipe_adder_if.slave (operand in, result out)
// Flow control is a global stall: every stage advances together when the output is
// empty or being taken, so in_ready depends only on out_valid/out_ready.
module csa_pipe_adder #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned BLK   = 16,
  parameter int unsigned GRP   = 2
) (
  input logic              clk,
  input logic              rst,
  csa_pipe_adder_if.slave  bus
);

  localparam int unsigned STAGES = WIDTH / (BLK * GRP);
  localparam int unsigned LAST   = STAGES - 1;

  // Stage registers: stage k holds the result of resolving blocks 0 .. (k+1)*GRP-1.
  logic             valid_q [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] x_q     [STAGES];
  logic [WIDTH-1:0] y_q     [STAGES];
  logic             xs_q    [STAGES];
  logic             ys_q    [STAGES];

  logic             valid_d [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] x_d     [STAGES];
  logic [WIDTH-1:0] y_d     [STAGES];
  logic             xs_d    [STAGES];
  logic             ys_d    [STAGES];

  logic advance;

  assign advance      = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] src_x;
    logic [WIDTH-1:0] src_y;
    logic [WIDTH-1:0] src_sum;
    logic             src_carry;
    logic             src_valid;
    logic             src_xs;
    logic             src_ys;
    logic [WIDTH-1:0] res_sum;
    logic [GRP:0]     carry;
    logic [BLK:0]     s0;
    logic [BLK:0]     s1;

    if (g == 0) begin : g_head
      // Subtraction is x + ~y + 1, so the forced carry-in replaces in_cin.
      assign src_x     = bus.in_x;
      assign src_y     = bus.in_sub ? ~bus.in_y : bus.in_y;
      assign src_carry = bus.in_sub | bus.in_cin;
      assign src_sum   = '0;
      assign src_valid = bus.in_valid & advance;
      assign src_xs    = bus.in_x[WIDTH-1];
      assign src_ys    = src_y[WIDTH-1];
    end else begin : g_body
      assign src_x     = x_q[g-1];
      assign src_y     = y_q[g-1];
      assign src_carry = carry_q[g-1];
      assign src_sum   = sum_q[g-1];
      assign src_valid = valid_q[g-1];
      assign src_xs    = xs_q[g-1];
      assign src_ys    = ys_q[g-1];
    end

    // Both block sums are formed independently of the incoming carry; only the select
    // ripples through the GRP blocks of this stage.
    always_comb begin
      int unsigned base;
      res_sum  = src_sum;
      carry    = '0;
      carry[0] = src_carry;
      s0       = '0;
      s1       = '0;
      base     = 0;
      for (int unsigned j = 0; j < GRP; j++) begin
        base = (unsigned'(g) * GRP + j) * BLK;
        s0 = {1'b0, src_x[base +: BLK]} + {1'b0, src_y[base +: BLK]};
        s1 = {1'b0, src_x[base +: BLK]} + {1'b0, src_y[base +: BLK]} + (BLK + 1)'(1);
        res_sum[base +: BLK] = carry[j] ? s1[BLK-1:0] : s0[BLK-1:0];
        carry[j+1]           = carry[j] ? s1[BLK] : s0[BLK];
      end
    end

    assign valid_d[g] = src_valid;
    assign carry_d[g] = carry[GRP];
    assign sum_d[g]   = res_sum;
    assign x_d[g]     = src_x;
    assign y_d[g]     = src_y;
    assign xs_d[g]    = src_xs;
    assign ys_d[g]    = src_ys;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        xs_q[k]    <= 1'b0;
        ys_q[k]    <= 1'b0;
      end
    end else if (advance) begin
      // Bubbles move with the data; nothing is collapsed.
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
        x_q[k]     <= x_d[k];
        y_q[k]     <= y_d[k];
        xs_q[k]    <= xs_d[k];
        ys_q[k]    <= ys_d[k];
      end
    end
  end

  assign bus.out_valid = valid_q[LAST];
  assign bus.out_sum   = sum_q[LAST];
  assign bus.out_cout  = carry_q[LAST];
  // Overflow: operands of equal sign producing a result of the other sign.
  assign bus.out_ovf   = (xs_q[LAST] == ys_q[LAST]) && (sum_q[LAST][WIDTH-1] != xs_q[LAST]);

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder. Three instances cover the parameter sweep
// (32,8,1), (64,16,4), (128,16,2); sel chooses which one receives stimulus and is
// observed. Expected results come from plain-arithmetic reference math.
module tb_csa_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  int           tests = 0;
  int           fails = 0;
  int           cyc   = 0;
  logic [1:0]   sel;

  logic         t_in_valid, t_cin, t_sub, t_out_ready;
  logic [127:0] t_x, t_y;
  logic         o_in_ready, o_out_valid, o_cout, o_ovf;
  logic [127:0] o_sum;

  typedef struct {
    logic [127:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  csa_pipe_adder_if #(.WIDTH(32))  if_a ();
  csa_pipe_adder_if #(.WIDTH(64))  if_b ();
  csa_pipe_adder_if #(.WIDTH(128)) if_c ();

  csa_pipe_adder #(.WIDTH(32), .BLK(8), .GRP(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  csa_pipe_adder #(.WIDTH(64), .BLK(16), .GRP(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  csa_pipe_adder #(.WIDTH(128), .BLK(16), .GRP(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.in_valid  = t_in_valid && (sel == 2'd0);
  assign if_a.in_x      = t_x[31:0];
  assign if_a.in_y      = t_y[31:0];
  assign if_a.in_cin    = t_cin;
  assign if_a.in_sub    = t_sub;
  assign if_a.out_ready = t_out_ready;

  assign if_b.in_valid  = t_in_valid && (sel == 2'd1);
  assign if_b.in_x      = t_x[63:0];
  assign if_b.in_y      = t_y[63:0];
  assign if_b.in_cin    = t_cin;
  assign if_b.in_sub    = t_sub;
  assign if_b.out_ready = t_out_ready;

  assign if_c.in_valid  = t_in_valid && (sel == 2'd2);
  assign if_c.in_x      = t_x;
  assign if_c.in_y      = t_y;
  assign if_c.in_cin    = t_cin;
  assign if_c.in_sub    = t_sub;
  assign if_c.out_ready = t_out_ready;

  always_comb begin
    case (sel)
      2'd0: begin
        o_in_ready  = if_a.in_ready;
        o_out_valid = if_a.out_valid;
        o_sum       = {96'b0, if_a.out_sum};
        o_cout      = if_a.out_cout;
        o_ovf       = if_a.out_ovf;
      end
      2'd1: begin
        o_in_ready  = if_b.in_ready;
        o_out_valid = if_b.out_valid;
        o_sum       = {64'b0, if_b.out_sum};
        o_cout      = if_b.out_cout;
        o_ovf       = if_b.out_ovf;
      end
      default: begin
        o_in_ready  = if_c.in_ready;
        o_out_valid = if_c.out_valid;
        o_sum       = if_c.out_sum;
        o_cout      = if_c.out_cout;
        o_ovf       = if_c.out_ovf;
      end
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(input logic [1:0] s);
    case (s)
      2'd0:    return 32;
      2'd1:    return 64;
      default: return 128;
    endcase
  endfunction

  // WIDTH / (BLK * GRP) for each instance.
  function automatic int stages_of(input logic [1:0] s);
    case (s)
      2'd0:    return 4;
      2'd1:    return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [127:0] ones_of(input int w);
    logic [127:0] v;
    v = '1;
    return v >> (128 - w);
  endfunction

  // Unsigned result from X + Y + cin or X - Y + 2^w; signed overflow from exact signed math.
  function automatic void ref_model(input int w, input logic [127:0] x, input logic [127:0] y,
                                    input logic cin, input logic sub,
                                    output logic [127:0] sum, output logic cout,
                                    output logic ovf);
    logic [129:0]        mask, xx, yy, tot;
    logic signed [129:0] sx, sy, st, hi, lo;
    mask = (130'd1 << w) - 130'd1;
    xx   = {2'b0, x} & mask;
    yy   = {2'b0, y} & mask;
    if (sub) tot = xx + (mask + 130'd1 - yy);
    else     tot = xx + yy + {129'b0, cin};
    cout = tot[w];
    tot  = tot & mask;
    sum  = tot[127:0];
    sx   = xx << (130 - w);
    sx   = sx >>> (130 - w);
    sy   = yy << (130 - w);
    sy   = sy >>> (130 - w);
    if (sub) st = sx - sy;
    else     st = sx + sy + $signed({129'b0, cin});
    hi   = (130'sd1 <<< (w - 1)) - 130'sd1;
    lo   = -hi - 130'sd1;
    ovf  = (st > hi) || (st < lo);
  endfunction

  function automatic logic [127:0] rand_op(input int w);
    logic [127:0] ones;
    ones = ones_of(w);
    case ($urandom_range(7))
      0:       return ones;
      1:       return '0;
      2:       return ones >> 1;
      3:       return ~(ones >> 1) & ones;
      4:       return 128'd1;
      default: return {$urandom(), $urandom(), $urandom(), $urandom()};
    endcase
  endfunction

  // Sends one beat into an idle pipeline and waits for its result (bounded).
  task automatic send_one(input logic [127:0] x, input logic [127:0] y, input logic cin,
                          input logic sub, output logic [127:0] s, output logic c,
                          output logic v, output int lat);
    int start;
    @(negedge clk);
    t_out_ready = 1'b1;
    t_x = x; t_y = y; t_cin = cin; t_sub = sub;
    t_in_valid = 1'b1;
    #1;
    start = cyc;
    @(negedge clk);
    t_in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (o_out_valid) begin
        lat = cyc - start;
        break;
      end
      @(negedge clk);
    end
    s = o_sum; c = o_cout; v = o_ovf;
  endtask

  task automatic run_stream(input int nbeats, input int valid_pct, input int ready_pct,
                            input bit lat_chk, output int ncyc);
    exp_t         q[$];
    exp_t         e;
    int           sent, guard, w, stg;
    bit           held;
    logic [127:0] h_sum, r_sum;
    logic         h_c, h_v, r_c, r_v;
    w = width_of(sel);
    stg = stages_of(sel);
    sent = 0; guard = 0; held = 0;
    h_sum = '0; h_c = 0; h_v = 0;
    while ((sent < nbeats || q.size() != 0) && guard < nbeats * 30 + 200) begin
      @(negedge clk);
      guard++;
      t_out_ready = ($urandom_range(99) < ready_pct);
      if (sent < nbeats && $urandom_range(99) < valid_pct) begin
        t_in_valid = 1'b1;
        t_x = rand_op(w); t_y = rand_op(w);
        t_cin = 1'($urandom_range(1)); t_sub = 1'($urandom_range(1));
      end else begin
        t_in_valid = 1'b0;
      end
      #1;
      tests++;
      if (o_in_ready !== (!o_out_valid || t_out_ready)) begin
        fails++;
        $display("FAIL in_ready_track: got %b want %b", o_in_ready, !o_out_valid || t_out_ready);
      end
      if (held) begin
        tests++;
        if (o_out_valid !== 1'b1 || o_sum !== h_sum || o_cout !== h_c || o_ovf !== h_v) begin
          fails++;
          $display("FAIL stall_hold: got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                   o_out_valid, o_sum, o_cout, o_ovf, h_sum, h_c, h_v);
        end
      end
      held  = o_out_valid && !t_out_ready;
      h_sum = o_sum; h_c = o_cout; h_v = o_ovf;
      if (o_out_valid && t_out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: got sum=%h with nothing outstanding, want none", o_sum);
        end else begin
          e = q.pop_front();
          if (o_sum !== e.sum || o_cout !== e.cout || o_ovf !== e.ovf) begin
            fails++;
            $display("FAIL result: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     o_sum, o_cout, o_ovf, e.sum, e.cout, e.ovf);
          end
          if (lat_chk) begin
            tests++;
            if (cyc - e.acc != stg) begin
              fails++;
              $display("FAIL latency: got %0d want %0d", cyc - e.acc, stg);
            end
          end
        end
      end
      if (t_in_valid && o_in_ready) begin
        ref_model(w, t_x, t_y, t_cin, t_sub, r_sum, r_c, r_v);
        e.sum = r_sum; e.cout = r_c; e.ovf = r_v; e.acc = cyc;
        q.push_back(e);
        sent++;
      end
    end
    t_in_valid = 1'b0;
    ncyc = guard;
    tests++;
    if (sent != nbeats || q.size() != 0) begin
      fails++;
      $display("FAIL stream_done: got sent=%0d pending=%0d want sent=%0d pending=0",
               sent, q.size(), nbeats);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      tests++;
      if (o_out_valid !== 1'b0 || o_sum !== '0 || o_cout !== 1'b0 || o_ovf !== 1'b0 ||
          o_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_state[%0d]: got v=%b sum=%h c=%b o=%b rdy=%b want 0,0,0,0,1",
                 s, o_out_valid, o_sum, o_cout, o_ovf, o_in_ready);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_carry_ripple;
    logic [127:0] s;
    logic         c, v;
    int           lat;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      send_one(ones_of(width_of(sel)), 128'd0, 1'b1, 1'b0, s, c, v, lat);
      tests++;
      if (s !== '0 || c !== 1'b1 || v !== 1'b0) begin
        fails++;
        $display("FAIL ripple[%0d]: got sum=%h c=%b o=%b want sum=0 c=1 o=0", k, s, c, v);
      end
      tests++;
      if (lat != stages_of(sel)) begin
        fails++;
        $display("FAIL ripple_latency[%0d]: got %0d want %0d", k, lat, stages_of(sel));
      end
    end
  endtask

  task automatic test_sub_borrow;
    logic [127:0] s;
    logic         c, v;
    int           lat;
    for (int k = 1; k < 3; k++) begin
      sel = 2'(k);
      // cin=1 must be ignored in subtract mode.
      send_one(128'd5, 128'd7, 1'b1, 1'b1, s, c, v, lat);
      tests++;
      if (s !== ones_of(width_of(sel)) - 128'd1 || c !== 1'b0 || v !== 1'b0) begin
        fails++;
        $display("FAIL sub_borrow[%0d]: got sum=%h c=%b o=%b want sum=%h c=0 o=0",
                 k, s, c, v, ones_of(width_of(sel)) - 128'd1);
      end
    end
  endtask

  task automatic test_signed_ovf;
    logic [127:0] s, maxp, minn;
    logic         c, v;
    int           lat;
    sel  = 2'd2;
    maxp = {1'b0, {127{1'b1}}};
    minn = {1'b1, 127'b0};
    send_one(maxp, 128'd1, 1'b0, 1'b0, s, c, v, lat);
    tests++;
    if (s !== minn || c !== 1'b0 || v !== 1'b1) begin
      fails++;
      $display("FAIL ovf_add: got sum=%h c=%b o=%b want sum=%h c=0 o=1", s, c, v, minn);
    end
    send_one(minn, 128'd1, 1'b0, 1'b1, s, c, v, lat);
    tests++;
    if (s !== maxp || c !== 1'b1 || v !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sub: got sum=%h c=%b o=%b want sum=%h c=1 o=1", s, c, v, maxp);
    end
  endtask

  task automatic test_reset_midstream;
    sel = 2'd2;
    t_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      t_in_valid = 1'b1;
      t_x = rand_op(128); t_y = rand_op(128);
      t_cin = 1'($urandom_range(1)); t_sub = 1'($urandom_range(1));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (o_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL rst_in_ready[%0d]: got %b want 1", i, o_in_ready);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    t_in_valid = 1'b0;
    #1;
    tests++;
    if (o_out_valid !== 1'b0 || o_sum !== '0 || o_cout !== 1'b0 || o_ovf !== 1'b0 ||
        o_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_state: got v=%b sum=%h c=%b o=%b rdy=%b want 0,0,0,0,1",
               o_out_valid, o_sum, o_cout, o_ovf, o_in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      tests++;
      if (o_out_valid !== 1'b0) begin
        fails++;
        $display("FAIL stale_beat[%0d]: got out_valid=%b want 0", i, o_out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    for (int k = 1; k < 3; k++) begin
      sel = 2'(k);
      run_stream(40, 100, 100, 1'b1, n);
      tests++;
      if (n != 40 + stages_of(sel)) begin
        fails++;
        $display("FAIL throughput[%0d]: got %0d cycles want %0d", k, n, 40 + stages_of(sel));
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    sel = 2'd2;
    run_stream(20, 70, 50, 1'b0, n);
  endtask

  task automatic test_sweep;
    int n;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      run_stream(1000, 80, 60, 1'b0, n);
    end
  endtask

  initial begin
    sel = 2'd0;
    t_in_valid = 1'b0; t_out_ready = 1'b1;
    t_x = '0; t_y = '0; t_cin = 1'b0; t_sub = 1'b0;
    test_reset();
    test_carry_ripple();
    test_sub_borrow();
    test_signed_ovf();
    test_reset_midstream();
    test_back_to_back();
    test_backpressure();
    test_sweep();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
